// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide beside the execute-stage ALU.
// Shift-add multiply and restoring divide, one operand bit per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FUNCT_LENGTH-1:0] Funct,
  input  logic [DATA_WIDTH-1:0]   SrcA,
  input  logic [DATA_WIDTH-1:0]   SrcB,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   MDResult
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;

  logic          op_div;
  logic          op_rem;
  logic          op_hi;
  logic          neg;
  logic          rneg;
  logic          spec;
  logic [DW-1:0] spec_q;
  logic [DW-1:0] acc;
  logic [DW-1:0] lo;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic          is_div;
  logic          sgn_a;
  logic          sgn_b;
  logic          neg_a;
  logic          neg_b;
  logic          div0;
  logic          ovf;
  logic          special;
  logic [DW-1:0] abs_a;
  logic [DW-1:0] abs_b;
  logic [DW-1:0] spec_val;

  // Decode the incoming request: signedness, magnitudes, special cases.
  always_comb begin
    is_div = Funct[2];
    if (is_div) begin
      sgn_a = ~Funct[0];
      sgn_b = ~Funct[0];
    end else begin
      sgn_a = Funct[1] ^ Funct[0];
      sgn_b = (Funct[1:0] == 2'b01);
    end
    neg_a = sgn_a & SrcA[DW-1];
    neg_b = sgn_b & SrcB[DW-1];
    abs_a = neg_a ? -SrcA : SrcA;
    abs_b = neg_b ? -SrcB : SrcB;
    div0 = is_div & (SrcB == '0);
    ovf = is_div & ~Funct[0] &
          (SrcA == MIN) & (SrcB == ONES);
    special = div0 | ovf;
    if (div0) spec_val = Funct[1] ? SrcA : ONES;
    else      spec_val = Funct[1] ? '0 : MIN;
  end

  logic [DW:0]   sum;
  logic [DW:0]   r_sh;
  logic [DW:0]   diff;
  logic [DW-1:0] acc_n;
  logic [DW-1:0] lo_n;

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
    r_sh = {acc, lo[DW-1]};
    diff = r_sh - {1'b0, dvs};
    if (op_div) begin
      if (diff[DW]) begin
        acc_n = r_sh[DW-1:0];
        lo_n  = {lo[DW-2:0], 1'b0};
      end else begin
        acc_n = diff[DW-1:0];
        lo_n  = {lo[DW-2:0], 1'b1};
      end
    end else begin
      acc_n = sum[DW:1];
      lo_n  = {sum[0], lo[DW-1:1]};
    end
  end

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;
  logic [DW-1:0]   fix_val;

  // Sign fix-up and result selection.
  always_comb begin
    prod = {acc, lo};
    if (neg) prod = -prod;
    quo = neg ? -lo : lo;
    rem = rneg ? -acc : acc;
    if (spec)
      fix_val = spec_q;
    else if (op_div)
      fix_val = op_rem ? rem : quo;
    else
      fix_val = op_hi ? prod[2*DW-1:DW] : prod[DW-1:0];
  end

  // Control FSM with registered busy/done and result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      MDResult <= '0;
      op_div   <= 1'b0;
      op_rem   <= 1'b0;
      op_hi    <= 1'b0;
      neg      <= 1'b0;
      rneg     <= 1'b0;
      spec     <= 1'b0;
      spec_q   <= '0;
      acc      <= '0;
      lo       <= '0;
      dvs      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_div <= is_div;
            op_rem <= Funct[1];
            op_hi  <= |Funct[1:0];
            neg    <= neg_a ^ neg_b;
            rneg   <= neg_a;
            spec   <= special;
            spec_q <= spec_val;
            acc    <= '0;
            lo     <= is_div ? abs_a : abs_b;
            dvs    <= is_div ? abs_b : abs_a;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= special ? FIX : CALC;
          end
        end
        CALC: begin
          if (cnt == CW'(DW)) begin
            state <= FIX;
          end else begin
            acc <= acc_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          MDResult <= fix_val;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
